// File: rtl/cpu_clk_gen.sv
// CPU clock generator: divides clk_56m to one of NUM_SPEEDS rates, switching speed only at
// falling edges of clk_cpu, with an optional low-phase gap after a switch and a pause stretch.
module cpu_clk_gen #(
    parameter int unsigned                  NUM_SPEEDS = 4,
    parameter int unsigned                  SEL_W      = 2,
    parameter int unsigned                  DIV_W      = 5,
    parameter logic [NUM_SPEEDS*DIV_W-1:0]  HALF_TABLE = {5'd7, 5'd2, 5'd4, 5'd8},
    parameter int unsigned                  SPEED_RST  = 0,
    parameter int unsigned                  GAP_CYCLES = 2
) (
    input  logic             clk_56m,
    input  logic             nRESET,
    input  logic [SEL_W-1:0] speed_sel,
    input  logic             pause,
    output logic             clk_cpu,
    output logic             ce_p,
    output logic             ce_n,
    output logic [SEL_W-1:0] cur_speed,
    output logic             busy,
    output logic             speed_ack
);

    localparam int unsigned GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam int unsigned GAP_LAST = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_GAP    = 2'd1,
        ST_LOWNEW = 2'd2
    } state_t;

    state_t             r_state;
    logic [DIV_W-1:0]   r_cnt;
    logic [GAP_W-1:0]   r_gap;
    logic               r_clk;
    logic               r_ce_p;
    logic               r_ce_n;
    logic               r_ack;
    logic               r_busy;
    logic [SEL_W-1:0]   r_cur;
    logic [SEL_W-1:0]   r_pend;
    logic               r_pending;

    state_t             w_state_nxt;
    logic [DIV_W-1:0]   w_cnt_nxt;
    logic [GAP_W-1:0]   w_gap_nxt;
    logic               w_clk_nxt;
    logic               w_ce_p_nxt;
    logic               w_ce_n_nxt;
    logic               w_ack_nxt;
    logic               w_busy_nxt;
    logic [SEL_W-1:0]   w_cur_nxt;
    logic [SEL_W-1:0]   w_pend_nxt;
    logic               w_pending_nxt;
    logic               w_commit;
    logic               w_phase_end;
    logic               w_sel_ok;
    logic [DIV_W-1:0]   w_half_raw;
    logic [DIV_W-1:0]   w_half_last;

    // Half-period lookup for the speed in effect; a zero entry behaves as 1
    always_comb begin
        w_half_raw = '0;
        for (int i = 0; i < NUM_SPEEDS; i++) begin
            if (r_cur == SEL_W'(i)) begin
                w_half_raw = HALF_TABLE[i*DIV_W +: DIV_W];
            end
        end
        w_half_last = (w_half_raw == '0) ? '0 : w_half_raw - DIV_W'(1);
    end

    assign w_sel_ok    = (32'(speed_sel) < NUM_SPEEDS);
    assign w_phase_end = (r_cnt == w_half_last);

    // Next-state, phase counting and request tracking
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_gap_nxt   = r_gap;
        w_clk_nxt   = r_clk;
        w_ce_p_nxt  = 1'b0;
        w_ce_n_nxt  = 1'b0;
        w_ack_nxt   = 1'b0;
        w_cur_nxt   = r_cur;
        w_commit    = 1'b0;

        case (r_state)
            ST_RUN: begin
                if (!w_phase_end) begin
                    w_cnt_nxt = r_cnt + DIV_W'(1);
                end else if (r_clk) begin
                    w_clk_nxt  = 1'b0;
                    w_ce_n_nxt = 1'b1;
                    w_cnt_nxt  = '0;
                    if (r_pending) begin
                        w_commit    = 1'b1;
                        w_cur_nxt   = r_pend;
                        w_gap_nxt   = '0;
                        w_state_nxt = (GAP_CYCLES > 0) ? ST_GAP : ST_LOWNEW;
                    end
                end else if (!pause) begin
                    w_clk_nxt  = 1'b1;
                    w_ce_p_nxt = 1'b1;
                    w_cnt_nxt  = '0;
                end
            end
            ST_GAP: begin
                if (r_gap != GAP_W'(GAP_LAST)) begin
                    w_gap_nxt = r_gap + GAP_W'(1);
                end else if (!pause) begin
                    w_state_nxt = ST_LOWNEW;
                    w_cnt_nxt   = '0;
                end
            end
            ST_LOWNEW: begin
                if (!w_phase_end) begin
                    w_cnt_nxt = r_cnt + DIV_W'(1);
                end else if (!pause) begin
                    w_clk_nxt   = 1'b1;
                    w_ce_p_nxt  = 1'b1;
                    w_ack_nxt   = 1'b1;
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_RUN;
                end
            end
            default: begin
                w_state_nxt = ST_RUN;
                w_cnt_nxt   = '0;
            end
        endcase

        // Requests compare against the speed that will be in effect next cycle
        w_pending_nxt = w_commit ? 1'b0 : r_pending;
        w_pend_nxt    = r_pend;
        if (w_sel_ok) begin
            if (speed_sel != w_cur_nxt) begin
                w_pending_nxt = 1'b1;
                w_pend_nxt    = speed_sel;
            end else begin
                w_pending_nxt = 1'b0;
            end
        end

        w_busy_nxt = w_pending_nxt || (w_state_nxt != ST_RUN);
    end

    // State and output registers
    always_ff @(posedge clk_56m) begin
        if (!nRESET) begin
            r_state   <= ST_RUN;
            r_cnt     <= '0;
            r_gap     <= '0;
            r_clk     <= 1'b0;
            r_ce_p    <= 1'b0;
            r_ce_n    <= 1'b0;
            r_ack     <= 1'b0;
            r_busy    <= 1'b0;
            r_cur     <= SEL_W'(SPEED_RST);
            r_pend    <= '0;
            r_pending <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_gap     <= w_gap_nxt;
            r_clk     <= w_clk_nxt;
            r_ce_p    <= w_ce_p_nxt;
            r_ce_n    <= w_ce_n_nxt;
            r_ack     <= w_ack_nxt;
            r_busy    <= w_busy_nxt;
            r_cur     <= w_cur_nxt;
            r_pend    <= w_pend_nxt;
            r_pending <= w_pending_nxt;
        end
    end

    assign clk_cpu   = r_clk;
    assign ce_p      = r_ce_p;
    assign ce_n      = r_ce_n;
    assign cur_speed = r_cur;
    assign busy      = r_busy;
    assign speed_ack = r_ack;

endmodule

// File: tb/tb_cpu_clk_gen.sv
// Bench for cpu_clk_gen: directed scenarios plus random sel/pause/reset traffic, every cycle
// compared against a phase-countdown reference model.
module tb_cpu_clk_gen;

    logic       clk_56m = 1'b0;
    logic       nRESET;
    logic [1:0] speed_sel;
    logic       pause;
    logic       clk_cpu, ce_p, ce_n, busy, speed_ack;
    logic [1:0] cur_speed;

    logic [1:0] sel3;
    logic       clk3, cep3, cen3, busy3, ack3;
    logic [1:0] cur3;

    always #5 clk_56m = ~clk_56m;

    cpu_clk_gen dut (
        .clk_56m(clk_56m), .nRESET(nRESET), .speed_sel(speed_sel), .pause(pause),
        .clk_cpu(clk_cpu), .ce_p(ce_p), .ce_n(ce_n), .cur_speed(cur_speed),
        .busy(busy), .speed_ack(speed_ack)
    );

    cpu_clk_gen #(.NUM_SPEEDS(3), .HALF_TABLE({5'd2, 5'd4, 5'd8})) dut3 (
        .clk_56m(clk_56m), .nRESET(nRESET), .speed_sel(sel3), .pause(1'b0),
        .clk_cpu(clk3), .ce_p(cep3), .ce_n(cen3), .cur_speed(cur3),
        .busy(busy3), .speed_ack(ack3)
    );

    int n_pass = 0;
    int n_total = 0;
    int n_cep, n_cen, n_ack;

    // Reference model: level, cycles remaining in the current phase, gap cycles remaining
    int tbl [4] = '{8, 4, 2, 7};
    localparam int GAP = 2;
    bit m_lvl, m_cep, m_cen, m_ack, m_busy, m_pv, m_sw;
    int m_rem, m_gap, m_cur, m_pend;

    function automatic int mhalf(input int s);
        return (tbl[s] == 0) ? 1 : tbl[s];
    endfunction

    task automatic model_reset();
        m_lvl = 0; m_cep = 0; m_cen = 0; m_ack = 0; m_busy = 0; m_pv = 0; m_sw = 0;
        m_cur = 0; m_pend = 0; m_gap = 0; m_rem = mhalf(0);
    endtask

    task automatic model_step(input int s, input bit p);
        int  ncur;
        bit  commit;
        ncur = m_cur; commit = 0;
        m_cep = 0; m_cen = 0; m_ack = 0;
        if (m_gap > 0) begin
            if (m_gap > 1) m_gap--;
            else if (!p) begin m_gap = 0; m_rem = mhalf(m_cur); end
        end else if (m_rem > 1) begin
            m_rem--;
        end else if (m_lvl) begin
            m_lvl = 0; m_cen = 1; m_rem = mhalf(m_cur);
            if (m_pv) begin
                ncur = m_pend; commit = 1; m_sw = 1;
                m_rem = mhalf(m_pend); m_gap = GAP;
            end
        end else if (!p) begin
            m_lvl = 1; m_cep = 1; m_rem = mhalf(m_cur);
            if (m_sw) begin m_ack = 1; m_sw = 0; end
        end
        if (commit) m_pv = 0;
        if (s < 4) begin
            if (s != ncur) begin m_pv = 1; m_pend = s; end
            else m_pv = 0;
        end
        m_cur  = ncur;
        m_busy = m_pv || m_sw;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk_56m);
        if (!nRESET) model_reset();
        else model_step(int'(speed_sel), pause);
        @(negedge clk_56m);
        chk("clk_cpu",   32'(clk_cpu),   32'(m_lvl));
        chk("ce_p",      32'(ce_p),      32'(m_cep));
        chk("ce_n",      32'(ce_n),      32'(m_cen));
        chk("speed_ack", 32'(speed_ack), 32'(m_ack));
        chk("busy",      32'(busy),      32'(m_busy));
        chk("cur_speed", 32'(cur_speed), 32'(m_cur));
        if (ce_p) n_cep++;
        if (ce_n) n_cen++;
        if (speed_ack) n_ack++;
    endtask

    task automatic wait_rise();
        int n = 0;
        do begin tick(); n++; end while (!ce_p && n < 300);
        if (!ce_p) chk("wait_rise_timeout", 32'(0), 32'(1));
    endtask

    task automatic wait_fall();
        int n = 0;
        do begin tick(); n++; end while (!ce_n && n < 300);
        if (!ce_n) chk("wait_fall_timeout", 32'(0), 32'(1));
    endtask

    task automatic wait_ack();
        int n = 0;
        do begin tick(); n++; end while (!speed_ack && n < 300);
        if (!speed_ack) chk("wait_ack_timeout", 32'(0), 32'(1));
    endtask

    // Length of the phase that began at the last toggle edge
    task automatic measure(output int n);
        logic start;
        start = clk_cpu;
        n = 0;
        do begin tick(); n++; end while (clk_cpu == start && n < 300);
    endtask

    initial begin
        int len;
        nRESET = 1'b0; speed_sel = 2'd0; pause = 1'b0; sel3 = 2'd0;
        repeat (3) tick();
        chk("rst_clk", 32'(clk_cpu), 32'(0));
        chk("rst_busy", 32'(busy), 32'(0));
        nRESET = 1'b1;

        // Speed 0: 8 high / 8 low, one ce_p and one ce_n per period
        wait_rise();
        measure(len); chk("s0_high", 32'(len), 32'(8));
        measure(len); chk("s0_low",  32'(len), 32'(8));
        n_cep = 0; n_cen = 0;
        repeat (16) tick();
        chk("s0_cep_per_period", 32'(n_cep), 32'(1));
        chk("s0_cen_per_period", 32'(n_cen), 32'(1));

        // Switch 0->3 requested in high phase
        speed_sel = 2'd3;
        tick();
        chk("sw_busy", 32'(busy), 32'(1));
        n_ack = 0;
        measure(len); chk("sw_high_rest", 32'(len), 32'(7));
        measure(len); chk("sw_low_gap",   32'(len), 32'(9));
        chk("sw_ack_at_rise", 32'(speed_ack), 32'(1));
        chk("sw_cur", 32'(cur_speed), 32'(3));
        measure(len); chk("s3_high", 32'(len), 32'(7));
        measure(len); chk("s3_low",  32'(len), 32'(7));
        chk("sw_ack_count", 32'(n_ack), 32'(1));

        // Pause held for 20 cycles from the start of a low phase
        wait_fall();
        pause = 1'b1;
        repeat (20) tick();
        chk("pause_held_low", 32'(clk_cpu), 32'(0));
        pause = 1'b0;
        tick();
        chk("pause_rise_after", 32'(clk_cpu), 32'(1));
        measure(len); chk("pause_high", 32'(len), 32'(7));

        // Back to speed 0, then a request that is withdrawn before the falling edge
        speed_sel = 2'd0;
        wait_ack();
        n_ack = 0;
        speed_sel = 2'd2;
        tick(); tick();
        speed_sel = 2'd0;
        tick();
        chk("cancel_busy", 32'(busy), 32'(0));
        wait_fall();
        measure(len); chk("cancel_low",  32'(len), 32'(8));
        measure(len); chk("cancel_high", 32'(len), 32'(8));
        chk("cancel_no_ack", 32'(n_ack), 32'(0));
        chk("cancel_cur", 32'(cur_speed), 32'(0));

        // Out-of-range select on a 3-speed instance
        sel3 = 2'd3;
        repeat (30) tick();
        chk("oor_cur3",  32'(cur3),  32'(0));
        chk("oor_busy3", 32'(busy3), 32'(0));
        sel3 = 2'd1;
        tick();
        chk("valid_busy3", 32'(busy3), 32'(1));

        // Reset during a high phase at speed 2
        speed_sel = 2'd2;
        wait_ack();
        chk("s2_cur", 32'(cur_speed), 32'(2));
        speed_sel = 2'd0;
        nRESET = 1'b0;
        tick();
        chk("midrst_clk", 32'(clk_cpu), 32'(0));
        chk("midrst_cur", 32'(cur_speed), 32'(0));
        nRESET = 1'b1;
        measure(len); chk("postrst_low",  32'(len), 32'(8));
        measure(len); chk("postrst_high", 32'(len), 32'(8));

        // Random speed changes, pause bursts and occasional resets
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 39) == 0) speed_sel = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) pause = ~pause;
            nRESET = ($urandom_range(0, 999) != 0);
            tick();
        end
        nRESET = 1'b1;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
